// File: rtl/pcs_receive.sv
`default_nettype none
// ============================================================================
// pcs_receive : 8b/10b PCS receive path (decode register + receive FSM).
// Optional macro PCS_RX_DISP_CHECK_EN adds running-disparity checking.
// Revision 1.0
// ============================================================================
module pcs_receive #(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [9:0]           SUDI,
    input  logic                 RX_EVEN,
    input  logic                 CODE_SYNC,
    output logic [7:0]           RXD,
    output logic                 RX_DV,
    output logic                 RX_ER,
    output logic                 RX_IDLE,
    output logic [ERR_CNT_W-1:0] ERR_CNT
);
    typedef enum logic [1:0] {
        WAIT_SYNC = 2'd0,
        IDLE      = 2'd1,
        RECEIVE   = 2'd2,
        RX_ERROR  = 2'd3
    } state_t;

    logic [5:0] g6;
    logic [3:0] g4, g4_dec;
    logic [2:0] ones6, ones4, d3;
    logic [4:0] d5;
    logic       v6, v4, mid_pos, mid_neg, mid_ok, is_k28, kx7, a7m, a7p;
    logic       a7, p7, k_flag, valid_tbl, valid;

    assign g6    = SUDI[9:4];
    assign g4    = SUDI[3:0];
    assign ones6 = 3'($countones(g6));
    assign ones4 = 3'($countones(g4));
    // K28 with positive starting disparity carries the complemented fghj forms
    assign g4_dec = (g6 == 6'b110000) ? ~g4 : g4;

    always_comb begin
        v6 = 1'b1;
        d5 = 5'd0;
        case (g6)
            6'b100111, 6'b011000: d5 = 5'd0;
            6'b011101, 6'b100010: d5 = 5'd1;
            6'b101101, 6'b010010: d5 = 5'd2;
            6'b110001:            d5 = 5'd3;
            6'b110101, 6'b001010: d5 = 5'd4;
            6'b101001:            d5 = 5'd5;
            6'b011001:            d5 = 5'd6;
            6'b111000, 6'b000111: d5 = 5'd7;
            6'b111001, 6'b000110: d5 = 5'd8;
            6'b100101:            d5 = 5'd9;
            6'b010101:            d5 = 5'd10;
            6'b110100:            d5 = 5'd11;
            6'b001101:            d5 = 5'd12;
            6'b101100:            d5 = 5'd13;
            6'b011100:            d5 = 5'd14;
            6'b010111, 6'b101000: d5 = 5'd15;
            6'b011011, 6'b100100: d5 = 5'd16;
            6'b100011:            d5 = 5'd17;
            6'b010011:            d5 = 5'd18;
            6'b110010:            d5 = 5'd19;
            6'b001011:            d5 = 5'd20;
            6'b101010:            d5 = 5'd21;
            6'b011010:            d5 = 5'd22;
            6'b111010, 6'b000101: d5 = 5'd23;
            6'b110011, 6'b001100: d5 = 5'd24;
            6'b100110:            d5 = 5'd25;
            6'b010110:            d5 = 5'd26;
            6'b110110, 6'b001001: d5 = 5'd27;
            6'b001110:            d5 = 5'd28;
            6'b001111, 6'b110000: d5 = 5'd28;
            6'b101110, 6'b010001: d5 = 5'd29;
            6'b011110, 6'b100001: d5 = 5'd30;
            6'b101011, 6'b010100: d5 = 5'd31;
            default:              v6 = 1'b0;
        endcase
    end

    always_comb begin
        v4 = 1'b1;
        d3 = 3'd0;
        case (g4_dec)
            4'b1011, 4'b0100:                   d3 = 3'd0;
            4'b1001:                            d3 = 3'd1;
            4'b0101:                            d3 = 3'd2;
            4'b1100, 4'b0011:                   d3 = 3'd3;
            4'b1101, 4'b0010:                   d3 = 3'd4;
            4'b1010:                            d3 = 3'd5;
            4'b0110:                            d3 = 3'd6;
            4'b1110, 4'b0001, 4'b0111, 4'b1000: d3 = 3'd7;
            default:                            v4 = 1'b0;
        endcase
    end

    // The fghj form must suit the disparity left behind by the abcdei sub-block
    assign mid_pos = (ones6 == 3'd4) || (g6 == 6'b000111);
    assign mid_neg = (ones6 == 3'd2) || (g6 == 6'b111000);
    assign mid_ok  = !(mid_pos && !((ones4 == 3'd1) || ((ones4 == 3'd2) && (g4 != 4'b1100))))
                  && !(mid_neg && !((ones4 == 3'd3) || ((ones4 == 3'd2) && (g4 != 4'b0011))));

    assign is_k28 = (g6 == 6'b001111) || (g6 == 6'b110000);
    assign kx7    = (g6 == 6'b111010) || (g6 == 6'b000101) || (g6 == 6'b110110) || (g6 == 6'b001001)
                 || (g6 == 6'b101110) || (g6 == 6'b010001) || (g6 == 6'b011110) || (g6 == 6'b100001);
    assign a7m    = (g6 == 6'b100011) || (g6 == 6'b010011) || (g6 == 6'b001011);
    assign a7p    = (g6 == 6'b110100) || (g6 == 6'b101100) || (g6 == 6'b011100);
    assign a7     = (g4 == 4'b0111) || (g4 == 4'b1000);
    assign p7     = (g4 == 4'b1110) || (g4 == 4'b0001);
    assign k_flag = is_k28 || (kx7 && a7);

    assign valid_tbl = v6 && v4 && mid_ok && !(is_k28 && p7)
                    && !(a7 && !k_flag && !(((g4 == 4'b0111) && a7m) || ((g4 == 4'b1000) && a7p)))
                    && !(((g4 == 4'b1110) && a7m) || ((g4 == 4'b0001) && a7p));

`ifdef PCS_RX_DISP_CHECK_EN
    logic       rd, need_known, need_pos, rd_err;
    logic [3:0] ones10;

    assign ones10 = {1'b0, ones6} + {1'b0, ones4};

    // Entry disparity is implied by the first unbalanced or alternate-form sub-block
    always_comb begin
        need_known = 1'b0;
        need_pos   = 1'b0;
        if ((ones6 != 3'd3) || (g6 == 6'b111000) || (g6 == 6'b000111)) begin
            need_known = 1'b1;
            need_pos   = (ones6 < 3'd3) || (g6 == 6'b000111);
        end else if ((ones4 != 3'd2) || (g4 == 4'b1100) || (g4 == 4'b0011)) begin
            need_known = 1'b1;
            need_pos   = (ones4 < 3'd2) || (g4 == 4'b0011);
        end
    end

    assign rd_err = need_known && (need_pos != rd);
    assign valid  = valid_tbl && !rd_err;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)
            rd <= 1'b0;
        else if (ones10 > 4'd5)
            rd <= 1'b1;
        else if (ones10 < 4'd5)
            rd <= 1'b0;
    end
`else
    assign valid = valid_tbl;
`endif

    logic [7:0] dec_octet;
    logic       dec_k, dec_valid, dec_sync, dec_even;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            dec_octet <= 8'h00;
            dec_k     <= 1'b0;
            dec_valid <= 1'b0;
            dec_sync  <= 1'b0;
            dec_even  <= 1'b0;
        end else begin
            dec_octet <= {d3, d5};
            dec_k     <= k_flag;
            dec_valid <= valid;
            dec_sync  <= CODE_SYNC;
            dec_even  <= RX_EVEN;
        end
    end

    logic is_k285, is_s, is_t;
    assign is_k285 = dec_valid && dec_k && (dec_octet == 8'hBC);
    assign is_s    = dec_valid && dec_k && (dec_octet == 8'hFB);
    assign is_t    = dec_valid && dec_k && (dec_octet == 8'hFD);

    state_t     state, state_nxt;
    logic [7:0] rxd_nxt;
    logic       dv_nxt, er_nxt;

    always_comb begin
        state_nxt = state;
        rxd_nxt   = 8'h00;
        dv_nxt    = 1'b0;
        er_nxt    = 1'b0;
        if (!dec_sync) begin
            state_nxt = WAIT_SYNC;
            if ((state == RECEIVE) || (state == RX_ERROR)) begin
                dv_nxt = 1'b1;
                er_nxt = 1'b1;
            end
        end else begin
            case (state)
                WAIT_SYNC: if (is_k285 && dec_even) state_nxt = IDLE;
                IDLE: begin
                    if (is_s && dec_even) begin
                        state_nxt = RECEIVE;
                        dv_nxt    = 1'b1;
                        rxd_nxt   = 8'h55;
                    end
                end
                RECEIVE: begin
                    if (is_t) begin
                        state_nxt = IDLE;
                    end else if (is_k285) begin
                        state_nxt = IDLE;
                        dv_nxt    = 1'b1;
                        er_nxt    = 1'b1;
                    end else if (!dec_valid || dec_k) begin
                        state_nxt = RX_ERROR;
                        dv_nxt    = 1'b1;
                        er_nxt    = 1'b1;
                    end else begin
                        dv_nxt  = 1'b1;
                        rxd_nxt = dec_octet;
                    end
                end
                RX_ERROR: begin
                    if (is_t || is_k285) begin
                        state_nxt = IDLE;
                    end else begin
                        dv_nxt = 1'b1;
                        er_nxt = 1'b1;
                    end
                end
                default: state_nxt = WAIT_SYNC;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= WAIT_SYNC;
            RXD   <= 8'h00;
            RX_DV <= 1'b0;
            RX_ER <= 1'b0;
        end else begin
            state <= state_nxt;
            RXD   <= rxd_nxt;
            RX_DV <= dv_nxt;
            RX_ER <= er_nxt;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)
            ERR_CNT <= '0;
        else if (!dec_valid && dec_sync && (ERR_CNT != '1))
            ERR_CNT <= ERR_CNT + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
    end

    assign RX_IDLE = (state == WAIT_SYNC) || (state == IDLE);

endmodule
`default_nettype wire
